// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/FLYING/DEAD FSM, native BCD score, optional best-score register.
// Latency: every output is registered; a response appears one cycle after the input is sampled.
// Backpressure: none; level/pulse inputs are consumed every cycle, nothing ever stalls.
//
// Ports:
//   clk, rst (async active-low)   clock and reset
//   restart, flap, pass, hit      debounced game inputs (flap is edge-detected internally)
//   state                         0 = IDLE, 1 = FLYING, 2 = DEAD
//   score_bcd, best_bcd           packed BCD, least significant digit in [3:0]
//   flap_pulse                    one-cycle boost request to the physics logic
//   score_sat                     high while the score is all nines
//
// Build option: define GAME_CTRL_HISCORE_EN to build the best-score register and
// comparator; without it best_bcd is tied to zero and the port list is unchanged.
module game_ctrl #(
   parameter int DIGITS    = 3,
   parameter int DEAD_HOLD = 1000,
   parameter int HOLD_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  flap,
   input  logic                  pass,
   input  logic                  hit,
   output logic [1:0]            state,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   best_bcd,
   output logic                  flap_pulse,
   output logic                  score_sat
);

   localparam int SW = 4*DIGITS;
   localparam logic [SW-1:0]     NINES    = {DIGITS{4'h9}};
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEAD_HOLD);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLYING = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       score_q, score_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                flap_prev_q, flap_prev_d;
   logic                flap_pulse_q, flap_pulse_d;
   logic                score_sat_q, score_sat_d;
   logic [SW-1:0]       score_inc;
   logic                carry;
   logic                flap_rise;

   assign flap_rise   = flap & ~flap_prev_q;
   assign flap_prev_d = flap;

   // Decimal ripple increment: a 9 rolls to 0 and passes the carry upward.
   // Only used when the score is not all nines, so the final carry is dropped.
   always_comb begin
      score_inc = score_q;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Next-state logic; priority is restart > hit > flap_rise.
   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      hold_d       = '0;
      flap_pulse_d = 1'b0;
      if (restart) begin
         state_d = ST_IDLE;
         score_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flap_rise) begin
                  state_d      = ST_FLYING;
                  score_d      = '0;
                  flap_pulse_d = 1'b1;
               end
            end
            ST_FLYING: begin
               if (hit) begin
                  state_d = ST_DEAD;
               end else begin
                  if (pass && (score_q != NINES)) score_d = score_inc;
                  if (flap_rise) flap_pulse_d = 1'b1;
               end
            end
            ST_DEAD: begin
               // Counter reaches DEAD_HOLD after DEAD_HOLD dead cycles; only then
               // is a flap accepted. The score stays visible on the way to IDLE.
               if (flap_rise && (hold_q == HOLD_MAX)) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      score_sat_d = (score_d == NINES);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         score_q      <= '0;
         hold_q       <= '0;
         flap_prev_q  <= 1'b1;   // flap held through reset release is not an edge
         flap_pulse_q <= 1'b0;
         score_sat_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         hold_q       <= hold_d;
         flap_prev_q  <= flap_prev_d;
         flap_pulse_q <= flap_pulse_d;
         score_sat_q  <= score_sat_d;
      end
   end

`ifdef GAME_CTRL_HISCORE_EN
   logic [SW-1:0] best_q, best_d;

   // Unsigned compare of packed BCD orders the same as the decimal values.
   always_comb begin
      best_d = best_q;
      if (!restart && (state_q == ST_FLYING) && hit && (score_q > best_q))
         best_d = score_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) best_q <= '0;
      else      best_q <= best_d;
   end

   assign best_bcd = best_q;
`else
   assign best_bcd = '0;
`endif

   assign state      = state_q;
   assign score_bcd  = score_q;
   assign flap_pulse = flap_pulse_q;
   assign score_sat  = score_sat_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: decimal-valued game model, per-cycle compare, directed plus random play.
// Latency: model steps on the same rising edge as the DUT; outputs compared on the falling edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_game_ctrl;

   localparam int D    = 3;
   localparam int HOLD = 8;
   localparam int MAXV = 10**D - 1;
`ifdef GAME_CTRL_HISCORE_EN
   localparam bit HS = 1'b1;
`else
   localparam bit HS = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           restart = 1'b0, flap = 1'b1, pass = 1'b0, hit = 1'b0;
   logic [1:0]     state;
   logic [4*D-1:0] score_bcd, best_bcd;
   logic           flap_pulse, score_sat;

   int errors = 0;
   int checks = 0;

   game_ctrl #(.DIGITS(D), .DEAD_HOLD(HOLD), .HOLD_W(16)) dut (
      .clk(clk), .rst(rst), .restart(restart), .flap(flap), .pass(pass), .hit(hit),
      .state(state), .score_bcd(score_bcd), .best_bcd(best_bcd),
      .flap_pulse(flap_pulse), .score_sat(score_sat)
   );

   always #5 clk = ~clk;

   // Model: game phase as an int, scores as plain decimal integers.
   int m_st, m_sc, m_best, m_dead;
   bit m_prev, m_pulse;

   function automatic logic [4*D-1:0] to_bcd(input int v);
      logic [4*D-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_st = 0; m_sc = 0; m_best = 0; m_dead = 0; m_prev = 1'b1; m_pulse = 1'b0;
      end else begin
         bit rise;
         rise    = flap && !m_prev;
         m_prev  = flap;
         m_pulse = 1'b0;
         if (restart) begin
            m_st = 0; m_sc = 0; m_dead = 0;
         end else if (m_st == 0) begin
            if (rise) begin m_st = 1; m_sc = 0; m_pulse = 1'b1; m_dead = 0; end
         end else if (m_st == 1) begin
            if (hit) begin
               m_st = 2; m_dead = 0;
               if (HS && m_sc > m_best) m_best = m_sc;
            end else begin
               if (pass && m_sc < MAXV) m_sc++;
               if (rise) m_pulse = 1'b1;
            end
         end else begin
            // m_dead = number of DEAD cycles already completed, capped at HOLD
            if (rise && m_dead >= HOLD) begin m_st = 0; m_dead = 0; end
            else if (m_dead < HOLD) m_dead++;
         end
      end
   end

   bit cmp_on = 1'b0;
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmp_state", 32'(state), 32'(m_st));
         chk("cmp_score", 32'(score_bcd), 32'(to_bcd(m_sc)));
         chk("cmp_best", 32'(best_bcd), 32'(to_bcd(m_best)));
         chk("cmp_pulse", 32'(flap_pulse), 32'(m_pulse));
         chk("cmp_sat", 32'(score_sat), 32'(m_sc == MAXV));
      end
   end

   task automatic step(input logic r, input logic h, input logic p, input logic f);
      restart = r; hit = h; pass = p; flap = f;
      @(negedge clk);
   endtask

   localparam logic [11:0] EXP42 = HS ? 12'h042 : 12'h000;

   initial begin
      logic fl;
      #1 rst = 1'b0;
      cmp_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_score", 32'(score_bcd), 32'd0);
      rst = 1'b1;                                   // released with flap held high
      repeat (4) step(0, 0, 0, 1);
      chk("flap_held_state", 32'(state), 32'd0);
      chk("flap_held_pulse", 32'(flap_pulse), 32'd0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("start_state", 32'(state), 32'd1);
      chk("start_pulse", 32'(flap_pulse), 32'd1);
      step(0, 0, 0, 1);
      chk("pulse_width", 32'(flap_pulse), 32'd0);

      repeat (42) step(0, 0, 1, 0);
      chk("score_42", 32'(score_bcd), 32'h042);
      step(0, 1, 1, 0);                             // pass and hit together
      chk("hit_state", 32'(state), 32'd2);
      chk("hit_score", 32'(score_bcd), 32'h042);
      chk("hit_best", 32'(best_bcd), 32'(EXP42));

      step(0, 0, 0, 0);                             // DEAD cycles 1, 2
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);                             // cycle 3: too early
      chk("dead_early_flap", 32'(state), 32'd2);
      repeat (6) step(0, 0, 0, 0);                  // cycles 4..9
      step(0, 0, 0, 1);                             // cycle 10
      chk("dead_exit_state", 32'(state), 32'd0);
      chk("dead_exit_score", 32'(score_bcd), 32'h042);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      chk("regame_state", 32'(state), 32'd1);
      chk("regame_score", 32'(score_bcd), 32'd0);

      repeat (17) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      chk("game2_score", 32'(score_bcd), 32'h017);
      chk("game2_best", 32'(best_bcd), 32'(EXP42));

      step(1, 0, 0, 0);
      chk("restart_state", 32'(state), 32'd0);
      step(0, 0, 0, 1);
      chk("game3_state", 32'(state), 32'd1);
      repeat (109) step(0, 0, 1, 0);
      chk("score_109", 32'(score_bcd), 32'h109);
      repeat (890) step(0, 0, 1, 0);
      chk("score_999", 32'(score_bcd), 32'h999);
      chk("sat_999", 32'(score_sat), 32'd1);
      step(0, 0, 1, 0);
      chk("score_sat_hold", 32'(score_bcd), 32'h999);
      chk("sat_hold", 32'(score_sat), 32'd1);

      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("restart_hit_state", 32'(state), 32'd0);
      chk("restart_hit_score", 32'(score_bcd), 32'd0);
      chk("restart_hit_best", 32'(best_bcd), 32'(EXP42));

      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (5) step(0, 0, 1, 0);
      #2 rst = 1'b0;                                // asynchronous mid-game reset
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_score", 32'(score_bcd), 32'd0);
      chk("async_best", 32'(best_bcd), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      fl = 1'b0;
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(3) == 0) fl = ~fl;
         step(($urandom_range(99) == 0), ($urandom_range(24) == 0),
              ($urandom_range(2) != 0), fl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
